// File: rtl/ledctrl_override.sv
// ledctrl_override: output stage between the LED bouncer and the board pins.
// AUTO mode passes i_bounce through. A Wishbone write to the LEDS register
// switches to MANUAL mode, where the CPU drives masked per-LED values dimmed
// by one global 5-bit PWM brightness.
// Optional feature macro: LEDCTRL_OVERRIDE_TIMEOUT_EN. When defined, MANUAL
// mode falls back to AUTO after 2^TIMEOUT_BITS-1 clocks without a LEDS write.
module ledctrl_override #(
    parameter int NLEDS        = 8,
    parameter int TIMEOUT_BITS = 28
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    input  logic             i_wb_we,
    input  logic             i_wb_addr,
    input  logic [31:0]      i_wb_data,
    input  logic [3:0]       i_wb_sel,
    output logic             o_wb_stall,
    output logic             o_wb_ack,
    output logic [31:0]      o_wb_data,
    input  logic [NLEDS-1:0] i_bounce,
    output logic [NLEDS-1:0] o_leds
);

    typedef enum logic {
        AUTO   = 1'b0,
        MANUAL = 1'b1
    } mode_t;

    mode_t            mode_q, mode_d;
    logic [NLEDS-1:0] led_reg_q, led_reg_d;
    logic [NLEDS-1:0] leds_q, leds_d;
    logic [NLEDS-1:0] man_on;
    logic [4:0]       bright_q, bright_d;
    logic [4:0]       pwm_q;
    logic [4:0]       br;
    logic             ack_q;
    logic [31:0]      rdata_q, rdata_d;
    logic [7:0]       leds8;
    logic             bus_req, wr_leds, wr_bright, force_auto, idle_expire;

`ifdef LEDCTRL_OVERRIDE_TIMEOUT_EN
    logic [TIMEOUT_BITS-1:0] idle_q, idle_d;
`endif

    // Only part of the data/select lanes are meaningful to this register map.
    logic unused_bits;
    assign unused_bits = ^{i_wb_sel, i_wb_data};

    assign o_wb_stall = 1'b0;
    assign o_wb_ack   = ack_q;
    assign o_wb_data  = rdata_q;
    assign o_leds     = leds_q;

    // Bus decode: every strobe inside a cycle is accepted immediately.
    always_comb begin
        bus_req    = i_wb_cyc && i_wb_stb;
        wr_leds    = bus_req && i_wb_we && !i_wb_addr;
        wr_bright  = bus_req && i_wb_we && i_wb_addr && i_wb_sel[0];
        force_auto = wr_leds && i_wb_sel[3] && i_wb_data[31];
    end

    // Idle expiry: the counter is about to reach zero on this clock.
`ifdef LEDCTRL_OVERRIDE_TIMEOUT_EN
    assign idle_expire = (mode_q == MANUAL) && (idle_q == TIMEOUT_BITS'(1));
`else
    assign idle_expire = 1'b0;
`endif

    // Mode FSM next state plus LED mask, brightness and idle counter updates.
    always_comb begin
        mode_d    = mode_q;
        led_reg_d = led_reg_q;
        bright_d  = bright_q;
`ifdef LEDCTRL_OVERRIDE_TIMEOUT_EN
        idle_d    = idle_q;
`endif
        case (mode_q)
            AUTO:    if (wr_leds && !force_auto) mode_d = MANUAL;
            MANUAL: begin
                // A LEDS write wins over a simultaneous idle expiry.
                if (wr_leds) mode_d = force_auto ? AUTO : MANUAL;
                else if (idle_expire) mode_d = AUTO;
            end
            default: mode_d = AUTO;
        endcase
        if (wr_leds) begin
            if (i_wb_sel[1] && i_wb_sel[0]) begin
                for (int k = 0; k < NLEDS; k++) begin
                    if (i_wb_data[8+k]) led_reg_d[k] = i_wb_data[k];
                end
            end
`ifdef LEDCTRL_OVERRIDE_TIMEOUT_EN
            if (!force_auto) idle_d = '1;
`endif
        end
`ifdef LEDCTRL_OVERRIDE_TIMEOUT_EN
        else if (mode_q == MANUAL && idle_q != '0) begin
            idle_d = idle_q - TIMEOUT_BITS'(1);
        end
`endif
        if (wr_bright) bright_d = i_wb_data[4:0];
    end

    // Read mux; data is captured on the accepted strobe and presented with ack.
    always_comb begin
        leds8              = '0;
        leds8[NLEDS-1:0]   = leds_q;
        rdata_d            = rdata_q;
        if (bus_req) begin
            if (i_wb_addr) rdata_d = {27'b0, bright_q};
            else           rdata_d = {(mode_q == MANUAL), 23'b0, leds8};
        end
    end

    // PWM: compare bit-reversed counter against brightness to spread on-time.
    always_comb begin
        for (int b = 0; b < 5; b++) br[b] = pwm_q[4-b];
        for (int k = 0; k < NLEDS; k++) begin
            man_on[k] = led_reg_q[k] &&
                        (bright_q == 5'd31 || (bright_q != 5'd0 && br <= bright_q));
        end
        leds_d = (mode_q == AUTO) ? i_bounce : man_on;
    end

    // State registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            mode_q    <= AUTO;
            led_reg_q <= '0;
            bright_q  <= 5'h1f;
            pwm_q     <= 5'd0;
            leds_q    <= '0;
            ack_q     <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            mode_q    <= mode_d;
            led_reg_q <= led_reg_d;
            bright_q  <= bright_d;
            pwm_q     <= pwm_q + 5'd1;
            leds_q    <= leds_d;
            ack_q     <= bus_req;
            rdata_q   <= rdata_d;
        end
    end

`ifdef LEDCTRL_OVERRIDE_TIMEOUT_EN
    // MANUAL idle counter.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) idle_q <= '0;
        else         idle_q <= idle_d;
    end
`endif

endmodule

// File: tb/tb_ledctrl_override.sv
// Bench for ledctrl_override: directed scenarios followed by random bus
// traffic, all checked against a cycle-level behavioural model.
module tb_ledctrl_override;
    localparam int NL   = 8;
    localparam int TBIT = 6;
    localparam int TOUT = (1 << TBIT) - 1;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr;
    logic [31:0] i_wb_data;
    logic [3:0]  i_wb_sel;
    logic        o_wb_stall, o_wb_ack;
    logic [31:0] o_wb_data;
    logic [7:0]  i_bounce;
    logic [7:0]  o_leds;

    ledctrl_override #(.NLEDS(NL), .TIMEOUT_BITS(TBIT)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
        .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_wb_sel(i_wb_sel),
        .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
        .i_bounce(i_bounce), .o_leds(o_leds)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_man, m_ack, m_rd;
    logic [7:0]  m_led, m_leds;
    logic [4:0]  m_bright, m_pwm;
    int          m_idle;
    logic [31:0] m_rdata;

    bit          n_man, req, wr0, frc;
    logic [7:0]  n_led;
    int          n_idle;
    logic [31:0] n_rd;

    function automatic logic [7:0] pwm_out(input logic [7:0] led, input logic [4:0] bri,
                                           input logic [4:0] ctr);
        logic [4:0] rev;
        rev = {<<{ctr}};
        if (bri == 5'd31 || (bri != 5'd0 && rev <= bri)) return led;
        return 8'h00;
    endfunction

    always_comb begin
        req   = i_wb_cyc && i_wb_stb;
        wr0   = req && i_wb_we && !i_wb_addr;
        frc   = wr0 && i_wb_sel[3] && i_wb_data[31];
        n_led = m_led;
        if (wr0 && i_wb_sel[1] && i_wb_sel[0])
            n_led = (m_led & ~i_wb_data[15:8]) | (i_wb_data[7:0] & i_wb_data[15:8]);
        n_man  = m_man;
        n_idle = m_idle;
        if (wr0) begin
            n_man = !frc;
            if (!frc) n_idle = TOUT;
        end else if (m_man) begin
`ifdef LEDCTRL_OVERRIDE_TIMEOUT_EN
            if (m_idle == 1) n_man = 1'b0;
            if (m_idle > 0) n_idle = m_idle - 1;
`endif
        end
        n_rd = i_wb_addr ? {27'b0, m_bright} : {m_man, 23'b0, m_leds};
    end

    always @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            m_man <= 1'b0; m_led <= 8'h00; m_leds <= 8'h00; m_bright <= 5'd31;
            m_pwm <= 5'd0; m_idle <= 0; m_ack <= 1'b0; m_rd <= 1'b0; m_rdata <= 32'd0;
        end else begin
            m_leds <= m_man ? pwm_out(m_led, m_bright, m_pwm) : i_bounce;
            m_pwm  <= m_pwm + 5'd1;
            m_ack  <= req;
            m_rd   <= req && !i_wb_we;
            if (req) m_rdata <= n_rd;
            m_man  <= n_man;
            m_led  <= n_led;
            m_idle <= n_idle;
            if (req && i_wb_we && i_wb_addr && i_wb_sel[0]) m_bright <= i_wb_data[4:0];
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge i_clk) begin
        if (chk_en) begin
            chk("leds", 32'(o_leds), 32'(m_leds));
            chk("ack", 32'(o_wb_ack), 32'(m_ack));
            chk("stall", 32'(o_wb_stall), 32'd0);
            if (m_ack && m_rd) chk("rdata", o_wb_data, m_rdata);
        end
    end

    // ---------------- stimulus ----------------
    task automatic bus(input bit we, input bit adr, input logic [31:0] d, input logic [3:0] sel);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
        i_wb_addr = adr; i_wb_data = d; i_wb_sel = sel;
        @(negedge i_clk);
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    endtask

    task automatic wr(input bit adr, input logic [31:0] d);
        bus(1'b1, adr, d, 4'hf);
    endtask

    task automatic rd(input string tag, input bit adr, input logic [31:0] exp);
        bus(1'b0, adr, 32'd0, 4'hf);
        chk(tag, o_wb_data, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    initial begin
        int cnt;
        i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0; i_wb_addr = 0;
        i_wb_data = 0; i_wb_sel = 0; i_bounce = 8'h00;
        i_reset = 1'b0;
        #1 i_reset = 1'b1;
        idle(3);
        chk("rst_leds", 32'(o_leds), 32'd0);
        chk("rst_ack", 32'(o_wb_ack), 32'd0);
        chk("rst_data", o_wb_data, 32'd0);
        i_reset = 1'b0;
        chk_en  = 1'b1;

        // 1: AUTO passthrough with one clock of latency
        i_bounce = 8'h5a;
        idle(1);
        chk("t1_leds", 32'(o_leds), 32'h5a);
        idle(3);
        rd("t1_rd0", 1'b0, 32'h0000_005a);
        rd("t1_rd1", 1'b1, 32'h0000_001f);

        // 2: take over, bouncer ignored
        wr(1'b0, 32'h0000_ff81);
        i_bounce = 8'h3c;
        idle(1);
        chk("t2_leds", 32'(o_leds), 32'h81);
        rd("t2_rd0", 1'b0, 32'h8000_0081);

        // 3: masked writes touch only masked LEDs
        wr(1'b0, 32'h0000_0200);
        idle(1);
        chk("t3_mask0", 32'(o_leds), 32'h81);
        wr(1'b0, 32'h0000_0202);
        idle(1);
        chk("t3_mask1", 32'(o_leds), 32'h83);

        // 4: brightness 5 gives 6 of 32 clocks on; brightness 0 is dark
        wr(1'b0, 32'h0000_ff01);
        wr(1'b1, 32'd5);
        idle(1);
        cnt = 0;
        repeat (32) begin @(negedge i_clk); cnt += int'(o_leds[0]); end
        chk("t4_duty5", 32'(cnt), 32'd6);
        wr(1'b0, 32'h0000_ff01);
        wr(1'b1, 32'd0);
        rd("t4_rdbr", 1'b1, 32'd0);
        cnt = 0;
        repeat (32) begin @(negedge i_clk); cnt += int'(o_leds[0]); end
        chk("t4_duty0", 32'(cnt), 32'd0);
        wr(1'b1, 32'd31);

        // 5: write exactly on the expiry clock keeps MANUAL
        wr(1'b0, 32'h0000_ff01);
        idle(TOUT - 1);
        wr(1'b0, 32'h0000_0000);
        rd("t5_hold", 1'b0, 32'h8000_0001);
        // idle well past the timeout
        idle(TOUT + 5);
`ifdef LEDCTRL_OVERRIDE_TIMEOUT_EN
        rd("t5_expire", 1'b0, 32'h0000_003c);
`else
        rd("t5_noexp", 1'b0, 32'h8000_0001);
        idle(1000);
        rd("t5_noexp1k", 1'b0, 32'h8000_0001);
`endif

        // 6: force-auto also clears masked LEDs; reset drops pending ack
        wr(1'b0, 32'h8000_ff00);
        idle(1);
        rd("t6_auto", 1'b0, 32'h0000_003c);
        wr(1'b0, 32'h0000_0000);
        idle(1);
        chk("t6_ledreg", 32'(o_leds), 32'h00);
        i_bounce = 8'hc3;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = 1'b0;
        #2 i_reset = 1'b1;
        #1 chk("t6_rst_leds", 32'(o_leds), 32'd0);
        chk("t6_rst_ack", 32'(o_wb_ack), 32'd0);
        @(negedge i_clk);
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        chk("t6_noack_in", 32'(o_wb_ack), 32'd0);
        i_reset = 1'b0;
        @(negedge i_clk);
        chk("t6_noack_out", 32'(o_wb_ack), 32'd0);
        chk("t6_auto_leds", 32'(o_leds), 32'hc3);

        // random traffic
        repeat (3000) begin
            int op;
            logic [31:0] d;
            i_bounce = 8'($urandom);
            op = int'($urandom_range(0, 11));
            d  = $urandom;
            case (op)
                4, 5:    bus(1'b0, 1'($urandom), 32'd0, 4'hf);
                6, 7:    bus(1'b1, 1'b0, {1'b0, d[30:0]}, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hf);
                8:       bus(1'b1, 1'b0, {1'b1, d[30:0]}, 4'($urandom));
                9:       bus(1'b1, 1'b1, d, 4'($urandom));
                default: idle(int'($urandom_range(1, (op == 10) ? 70 : 3)));
            endcase
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
